// File: rtl/shift_add_multiplier_if.sv
// rtl/shift_add_multiplier_if.sv - operand/product handshake bundle for shift_add_multiplier
interface shift_add_multiplier_if #(
    parameter int WIDTH = 4
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier, one multiplier bit per clock
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic                 last_iter;

    assign accept    = bus.in_valid && (state == IDLE);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (last_iter)     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // product is wired straight from acc, so it clears the moment reset asserts
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.product   = acc;
    end

    // Fixed WIDTH iterations even when the remaining multiplier bits are zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= {{WIDTH{1'b0}}, bus.a};
                        mplier <= bus.b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier at WIDTH 4 and 8
module tb_shift_add_multiplier;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    shift_add_multiplier_if #(.WIDTH(4)) bus4 ();
    shift_add_multiplier_if #(.WIDTH(8)) bus8 ();

    shift_add_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        output logic [7:0] p, output int lat);
        @(negedge clk);
        bus4.a = a; bus4.b = b; bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        p = bus4.product;
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat);
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        p = bus8.product;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0]  p4;
        logic [15:0] p8;
        logic [7:0]  ra4, rb4;
        logic [15:0] ra8, rb8;
        int lat, low_cnt, valid_at, extra;

        n_cmp = 0; n_fail = 0;
        vecs[0] = '{4'd0,  4'd2,  8'd0};
        vecs[1] = '{4'd1,  4'd2,  8'd2};
        vecs[2] = '{4'd2,  4'd2,  8'd4};
        vecs[3] = '{4'd3,  4'd2,  8'd6};
        vecs[4] = '{4'd4,  4'd2,  8'd8};
        vecs[5] = '{4'd8,  4'd2,  8'd16};
        vecs[6] = '{4'd15, 4'd2,  8'd30};
        vecs[7] = '{4'd15, 4'd15, 8'd225};
        vecs[8] = '{4'd0,  4'd13, 8'd0};
        vecs[9] = '{4'd9,  4'd0,  8'd0};

        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b0;
        #2;
        check("reset_in_ready",  64'(bus4.in_ready),  64'd1);
        check("reset_out_valid", 64'(bus4.out_valid), 64'd0);
        check("reset_product",   64'(bus4.product),   64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full-scale operand with out_ready already high: in_ready low for 5 cycles
        @(negedge clk);
        bus4.a = 4'd15; bus4.b = 4'd15; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
        low_cnt = 0; valid_at = -1; p4 = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus4.in_valid = 1'b0;
            if (!bus4.in_ready) low_cnt++;
            if (bus4.out_valid && valid_at < 0) begin
                valid_at = i;
                p4 = bus4.product;
            end
        end
        bus4.out_ready = 1'b0;
        check("full_in_ready_low", 64'(low_cnt),  64'd5);
        check("full_valid_edge",   64'(valid_at), 64'd4);
        check("full_product",      64'(p4),       64'd225);

        for (int i = 0; i < 10; i++) begin
            run4(vecs[i].a, vecs[i].b, p4, lat);
            check($sformatf("vec%0d_product", i), 64'(p4),  64'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
        end

        for (int i = 0; i < 10; i++) begin
            ra4 = 8'($urandom_range(0, 15));
            rb4 = 8'($urandom_range(0, 15));
            run4(ra4[3:0], rb4[3:0], p4, lat);
            check($sformatf("rand4_%0d_product", i), 64'(p4), 64'(ra4 * rb4));
        end

        for (int i = 0; i < 20; i++) begin
            ra8 = 16'($urandom_range(0, 255));
            rb8 = 16'($urandom_range(0, 255));
            if (i == 0) begin ra8 = 16'd255; rb8 = 16'd255; end
            run8(ra8[7:0], rb8[7:0], p8, lat);
            check($sformatf("rand8_%0d_product", i), 64'(p8),  64'(ra8 * rb8));
            check($sformatf("rand8_%0d_latency", i), 64'(lat), 64'd8);
        end

        // Backpressure: 6*7 held for 7 cycles
        @(negedge clk);
        bus4.a = 4'd6; bus4.b = 4'd7; bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("bp_hold%0d_valid", i),   64'(bus4.out_valid), 64'd1);
            check($sformatf("bp_hold%0d_product", i), 64'(bus4.product),   64'd42);
            @(negedge clk);
        end
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        check("bp_release_valid", 64'(bus4.out_valid), 64'd0);
        check("bp_release_ready", 64'(bus4.in_ready),  64'd1);

        // in_valid during RUN must be ignored
        @(negedge clk);
        bus4.a = 4'd5; bus4.b = 4'd3; bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
        @(negedge clk);
        bus4.a = 4'd1; bus4.b = 4'd1;
        @(negedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        lat = 2;
        while (!bus4.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("busy_latency", 64'(lat),           64'd4);
        check("busy_product", 64'(bus4.product),  64'd15);
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus4.out_valid) extra++;
        end
        check("busy_no_second_result", 64'(extra), 64'd0);

        // Asynchronous reset during the 2nd RUN cycle of 12*11
        @(negedge clk);
        bus4.a = 4'd12; bus4.b = 4'd11; bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        check("midreset_busy", 64'(bus4.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(bus4.out_valid), 64'd0);
        check("midreset_product",   64'(bus4.product),   64'd0);
        check("midreset_in_ready",  64'(bus4.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run4(4'd3, 4'd3, p4, lat);
        check("post_reset_product", 64'(p4),  64'd9);
        check("post_reset_latency", 64'(lat), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
